alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_pkg.sv | 20 ++
 rtl/alu_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_alu_seq_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the byte-serial ALU sequencer: FSM encoding,
// opcode field positions and default widths.
package alu_seq_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int SEL_W_DEF  = 3;

  // Opcode byte layout: ALU select in the low bits, chain request in bit 7.
  localparam int SEL_LSB   = 0;
  localparam int CHAIN_BIT = 7;

  typedef enum logic [2:0] {
    GET_A,
    GET_B,
    GET_OP,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Collects A, B and opcode bytes, drives an external combinational ALU and
// returns the registered result. Optional accumulate chaining: ALU_SEQ_CHAIN_EN.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cout,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_cout,
  input  logic              out_ready,
  output logic              busy,
  output logic [7:0]        op_count
);

  state_t            state, next_state;
  logic [DATA_W-1:0] reg_a, reg_b;
  // Only the opcode bits that matter are kept; the rest of the byte is dropped.
  logic [SEL_W-1:0]  reg_sel;
`ifdef ALU_SEQ_CHAIN_EN
  logic              reg_chain;
`endif
  logic              accept, resp_done;

  assign alu_a   = reg_a;
  assign alu_b   = reg_b;
  assign alu_sel = reg_sel;

  assign accept    = in_valid && in_ready;
  assign resp_done = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= GET_A;
    else     state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state)
      GET_A: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) next_state = GET_B;
      end
      GET_B: begin
        in_ready = 1'b1;
        if (in_valid) next_state = GET_OP;
      end
      GET_OP: begin
        in_ready = 1'b1;
        if (in_valid) next_state = EXEC;
      end
      EXEC: next_state = RESP;
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) begin
`ifdef ALU_SEQ_CHAIN_EN
          next_state = reg_chain ? GET_B : GET_A;
`else
          next_state = GET_A;
`endif
        end
      end
      default: next_state = GET_A;
    endcase
  end

  // NOTE: every datapath register is reset here, so a partial command is
  // discarded and the first cycle after reset sees clean operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_a     <= '0;
      reg_b     <= '0;
      reg_sel   <= '0;
`ifdef ALU_SEQ_CHAIN_EN
      reg_chain <= 1'b0;
`endif
      out_data  <= '0;
      out_cout  <= 1'b0;
      op_count  <= '0;
    end else begin
      if (accept && state == GET_A) reg_a <= in_data;
      if (accept && state == GET_B) reg_b <= in_data;
      if (accept && state == GET_OP) begin
        reg_sel   <= in_data[SEL_LSB +: SEL_W];
`ifdef ALU_SEQ_CHAIN_EN
        reg_chain <= in_data[CHAIN_BIT];
`endif
      end
      if (state == EXEC) begin
        out_data <= alu_result;
        out_cout <= alu_cout;
      end
      if (resp_done) begin
        op_count <= op_count + 8'd1;
`ifdef ALU_SEQ_CHAIN_EN
        // Chained command: the result becomes the next A operand.
        if (reg_chain) reg_a <= out_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with an external add/sub ALU model and a
// command-level reference model checked every cycle.
module tb_alu_seq_ctrl;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [SEL_W-1:0]  alu_sel;
  logic [DATA_W-1:0] alu_result;
  logic              alu_cout;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_cout;
  logic              out_ready;
  logic              busy;
  logic [7:0]        op_count;

  alu_seq_ctrl #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_result(alu_result),
    .alu_cout  (alu_cout),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_cout  (out_cout),
    .out_ready (out_ready),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  // External ALU: sel 0 adds with carry, sel 1 subtracts (cout = borrow).
  always_comb begin
    case (alu_sel)
      3'd0:    {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1:    {alu_cout, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
      default: {alu_cout, alu_result} = {1'b0, alu_a ^ alu_b};
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: parses the accepted byte stream into commands.
  typedef struct {
    logic [7:0] data;
    logic       cout;
  } result_t;

  result_t    exp_q[$];
  int         phase = 0;
  logic [7:0] m_a, m_b;
  logic [7:0] m_count = 8'd0;
`ifdef ALU_SEQ_CHAIN_EN
  bit         chain_en = 1'b1;
`else
  bit         chain_en = 1'b0;
`endif
  bit         mon_en = 1'b0;

  function automatic void model_reset();
    exp_q.delete();
    phase   = 0;
    m_count = 8'd0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic [8:0] s;
    result_t    r;
    case (phase)
      0: begin m_a = b; phase = 1; end
      1: begin m_b = b; phase = 2; end
      default: begin
        case (b[2:0])
          3'd0:    s = {1'b0, m_a} + {1'b0, m_b};
          3'd1:    s = {1'b0, m_a} - {1'b0, m_b};
          default: s = {1'b0, m_a ^ m_b};
        endcase
        r.data = s[7:0];
        r.cout = s[8];
        exp_q.push_back(r);
        if (chain_en && b[7]) begin
          m_a   = r.data;
          phase = 1;
        end else begin
          phase = 0;
        end
      end
    endcase
  endfunction

  // Per-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      check("ready_valid_overlap", {31'b0, in_ready && out_valid}, 32'd0);
      check("op_count_model", {24'b0, op_count}, {24'b0, m_count});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got out_valid=1, expected 0 (t=%0t)", $time);
        end else begin
          check("out_data_model", {24'b0, out_data}, {24'b0, exp_q[0].data});
          check("out_cout_model", {31'b0, out_cout}, {31'b0, exp_q[0].cout});
          if (out_ready) begin
            void'(exp_q.pop_front());
            m_count = m_count + 8'd1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 50; i++) begin
      acc = in_ready;
      tick();
      if (acc) break;
    end
    in_valid = 1'b0;
    if (acc) model_byte(b);
    else check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    send_byte(a);
    send_byte(b);
    send_byte(op);
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 50; i++) begin
      if (out_valid) break;
      tick();
    end
    if (!out_valid) check("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic recv();
    logic v;
    v         = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      v = out_valid;
      tick();
      if (v) break;
    end
    out_ready = 1'b0;
    if (!v) check("recv_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  {31'b0, in_ready},  32'd1);
    check({tag, "_busy"},      {31'b0, busy},      32'd0);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_out_data"},  {24'b0, out_data},  32'd0);
    check({tag, "_out_cout"},  {31'b0, out_cout},  32'd0);
    check({tag, "_op_count"},  {24'b0, op_count},  32'd0);
    check({tag, "_alu_a"},     {24'b0, alu_a},     32'd0);
    check({tag, "_alu_b"},     {24'b0, alu_b},     32'd0);
    check({tag, "_alu_sel"},   {29'b0, alu_sel},   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    tick();
    tick();
    rst    = 1'b0;
    mon_en = 1'b1;
    check_idle("reset");

    // Basic add: 0x0F + 0x01; out_valid exactly two cycles after the opcode byte.
    send3(8'h0F, 8'h01, 8'h00);
    check("add_exec_out_valid", {31'b0, out_valid}, 32'd0);
    check("add_exec_busy", {31'b0, busy}, 32'd1);
    tick();
    check("add_resp_out_valid", {31'b0, out_valid}, 32'd1);
    check("add_out_data", {24'b0, out_data}, 32'h10);
    check("add_out_cout", {31'b0, out_cout}, 32'd0);
    recv();
    check("add_op_count", {24'b0, op_count}, 32'd1);
    check("add_back_to_get_a", {31'b0, in_ready}, 32'd1);

    // Carry with 5 cycles of backpressure; stray input must be ignored.
    send3(8'hFF, 8'h02, 8'h00);
    tick();
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_out_data", {24'b0, out_data}, 32'h01);
      check("bp_out_cout", {31'b0, out_cout}, 32'd1);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    recv();
    check("bp_op_count", {24'b0, op_count}, 32'd2);

    // Gapped input; opcode 0x79 selects subtract with bits 6..3 ignored.
    begin
      logic [7:0] gbytes [3];
      gbytes[0] = 8'h30;
      gbytes[1] = 8'h12;
      gbytes[2] = 8'h79;
      for (int i = 0; i < 3; i++) begin
        in_valid = 1'b0;
        in_data  = 8'hA5;
        tick();
        send_byte(gbytes[i]);
      end
    end
    wait_resp();
    check("gap_out_data", {24'b0, out_data}, 32'h1E);
    check("gap_out_cout", {31'b0, out_cout}, 32'd0);
    recv();
    check("gap_op_count", {24'b0, op_count}, 32'd3);

    // Reset while waiting for the opcode byte.
    send_byte(8'h11);
    send_byte(8'h22);
    in_valid = 1'b1;
    in_data  = 8'h00;
    rst      = 1'b1;
    model_reset();
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check_idle("rst_get_op");

    // Reset wins over a RESP handshake: the operation is not counted.
    send3(8'h01, 8'h02, 8'h00);
    wait_resp();
    out_ready = 1'b1;
    rst       = 1'b1;
    model_reset();
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    check_idle("rst_resp");

    // Counter wrap after 256 operations.
    for (int i = 0; i < 256; i++) begin
      send3(8'(i), 8'h01, 8'h00);
      recv();
      if (i == 254) check("wrap_count_255", {24'b0, op_count}, 32'd255);
    end
    check("wrap_count_0", {24'b0, op_count}, 32'd0);

    // Chaining request in opcode bit 7.
    send3(8'h05, 8'h03, 8'h80);
    wait_resp();
    check("chain1_out_data", {24'b0, out_data}, 32'h08);
    recv();
    check("chain1_op_count", {24'b0, op_count}, 32'd1);
`ifdef ALU_SEQ_CHAIN_EN
    check("chain_busy", {31'b0, busy}, 32'd1);
    check("chain_alu_a", {24'b0, alu_a}, 32'h08);
    send_byte(8'h02);
    send_byte(8'h00);
    wait_resp();
    check("chain2_out_data", {24'b0, out_data}, 32'h0A);
`else
    check("nochain_busy", {31'b0, busy}, 32'd0);
    send3(8'h02, 8'h00, 8'h00);
    wait_resp();
    check("chain2_out_data", {24'b0, out_data}, 32'h02);
`endif
    recv();
    check("chain2_op_count", {24'b0, op_count}, 32'd2);
    tick();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
